// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step motion controller.
//  - state_t          : move sequencer states
//  - DEF_START_PERIOD : default start/stop period in clk cycles
//  - DEF_RAMP_DELTA   : default period change per ramp step
//  - MIN_PERIOD       : smallest usable cruise period (one idle cycle between pulses)
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } state_t;

  localparam int DEF_START_PERIOD = 1000;
  localparam int DEF_RAMP_DELTA   = 50;
  localparam int MIN_PERIOD       = 2;

endpackage

// File: rtl/step_rate_gen.sv
// Step interval counter.
//  clk    : system clock
//  rst    : asynchronous reset, active-low
//  clr    : synchronous clear of the counter (wins over counting)
//  period : current interval length in clk cycles (>= 2)
//  tick   : high while the counter sits at period-1, i.e. the interval has elapsed
module step_rate_gen #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = (cnt == period - DIV_W'(1));

endmodule

// File: rtl/step_motion_controller.sv
// Move sequencer for the stepper phase FSM.
// Accepts a move command (steps, direction, full/half, cruise period) and emits
// make_step pulses following a linear trapezoidal ramp that starts and ends at
// START_PERIOD. Direction and step size are latched for the whole move.
//  clk        : system clock
//  rst        : asynchronous reset, active-low
//  cmd_valid  : move command present
//  cmd_ready  : controller idle; command taken when cmd_valid && cmd_ready
//  cmd_steps  : number of pulses to issue
//  cmd_dir    : 1 = clockwise, 0 = counter-clockwise
//  cmd_full   : 1 = full step, 0 = half step
//  cmd_period : cruise period in clk cycles (values below 2 are raised to 2)
//  abort      : level, requests a controlled stop through deceleration
//  make_step  : one-cycle step pulse
//  dir_out    : latched direction
//  full_out   : latched step size
//  busy       : move in progress
//  done       : one-cycle pulse when a move finishes
//  steps_left : remaining pulses of the current move
module step_motion_controller
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DIV_W        = 20,
  parameter int START_PERIOD = DEF_START_PERIOD,
  parameter int RAMP_DELTA   = DEF_RAMP_DELTA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             cmd_full,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             make_step,
  output logic             dir_out,
  output logic             full_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam logic [DIV_W-1:0] START_P = DIV_W'(START_PERIOD);
  localparam logic [DIV_W-1:0] DELTA   = DIV_W'(RAMP_DELTA);
  localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(MIN_PERIOD);

  // The period always stays within [cruise, START_P], so both differences
  // below are non-negative and the steps saturate instead of wrapping.
  function automatic logic [DIV_W-1:0] sat_add(input logic [DIV_W-1:0] p);
    return (START_P - p <= DELTA) ? START_P : p + DELTA;
  endfunction

  function automatic logic [DIV_W-1:0] sat_sub(input logic [DIV_W-1:0] p,
                                               input logic [DIV_W-1:0] floor_p);
    return (p - floor_p <= DELTA) ? floor_p : p - DELTA;
  endfunction

  state_t           state, state_nxt;
  logic [DIV_W-1:0] period_q, period_nxt;
  logic [DIV_W-1:0] cruise_q, cruise_nxt;
  logic [CNT_W-1:0] ramp_q, ramp_nxt;
  logic [CNT_W-1:0] steps_left_nxt;
  logic             dir_nxt, full_nxt, make_step_nxt, done_nxt;

  logic             tick, fire, rate_clr;
  logic [DIV_W-1:0] pc_in;
  logic [CNT_W-1:0] sl_dec, ramp_inc, sl_abort;
  logic [DIV_W-1:0] p_acc, p_up;

  assign busy      = (state != IDLE);
  assign cmd_ready = ~busy;

  // A step is due when the interval elapses during a move; the counter is
  // held at zero while idle so the first interval is measured from accept.
  assign fire     = tick & busy;
  assign rate_clr = ~busy | fire;

  step_rate_gen #(.DIV_W(DIV_W)) u_rate (
    .clk    (clk),
    .rst    (rst),
    .clr    (rate_clr),
    .period (period_q),
    .tick   (tick)
  );

  assign pc_in    = (cmd_period < MIN_P) ? MIN_P : cmd_period;
  assign sl_dec   = steps_left - CNT_W'(1);
  assign ramp_inc = (state == ACCEL) ? ramp_q + CNT_W'(1) : ramp_q;
  assign p_acc    = (state == ACCEL) ? sat_sub(period_q, cruise_q) : period_q;
  assign p_up     = sat_add(period_q);
  assign sl_abort = (steps_left < ramp_q) ? steps_left : ramp_q;

  // Step bookkeeping runs on the cycle the pulse is visible, so the counter
  // (cleared on the pulse edge) is at most 1 and cannot tick at the same time.
  // NOTE: every signal written here gets its default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    period_nxt     = period_q;
    cruise_nxt     = cruise_q;
    ramp_nxt       = ramp_q;
    steps_left_nxt = steps_left;
    dir_nxt        = dir_out;
    full_nxt       = full_out;
    make_step_nxt  = fire;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dir_nxt        = cmd_dir;
          full_nxt       = cmd_full;
          steps_left_nxt = cmd_steps;
          ramp_nxt       = '0;
          cruise_nxt     = pc_in;
          period_nxt     = (pc_in < START_P) ? START_P : pc_in;
          if (cmd_steps == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = (pc_in < START_P) ? ACCEL : CRUISE;
          end
        end
      end

      default: begin
        if (make_step) begin
          steps_left_nxt = sl_dec;
          if (sl_dec == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (state == DECEL) begin
            period_nxt = p_up;
          end else begin
            ramp_nxt = ramp_inc;
            if (sl_dec <= ramp_inc) begin
              // Braking point reached: the period climbs back from the
              // interval just completed, mirroring the acceleration side.
              state_nxt  = DECEL;
              period_nxt = p_up;
            end else begin
              period_nxt = p_acc;
              if (state == ACCEL && p_acc == cruise_q) begin
                state_nxt = CRUISE;
              end
            end
          end
        end else if (abort && !fire && state != DECEL) begin
          // Keep only as many steps as it takes to ramp back down.
          steps_left_nxt = sl_abort;
          if (sl_abort == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt  = DECEL;
            period_nxt = p_up;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      period_q   <= START_P;
      cruise_q   <= START_P;
      ramp_q     <= '0;
      steps_left <= '0;
      dir_out    <= 1'b1;
      full_out   <= 1'b1;
      make_step  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      period_q   <= period_nxt;
      cruise_q   <= cruise_nxt;
      ramp_q     <= ramp_nxt;
      steps_left <= steps_left_nxt;
      dir_out    <= dir_nxt;
      full_out   <= full_nxt;
      make_step  <= make_step_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_step_motion_controller.sv
// Scoreboard bench for step_motion_controller (START_PERIOD=20, RAMP_DELTA=5).
// The driver computes each move's pulse schedule from the ramp rules and
// queues it; a monitor pops and compares whenever make_step or done appears.
module tb_step_motion_controller;

  localparam int CNT_W = 16;
  localparam int DIV_W = 20;
  localparam int SP    = 20;
  localparam int RD    = 5;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready, cmd_dir, cmd_full, abort;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             make_step, dir_out, full_out, busy, done;
  logic [CNT_W-1:0] steps_left;

  step_motion_controller #(
    .CNT_W(CNT_W), .DIV_W(DIV_W), .START_PERIOD(SP), .RAMP_DELTA(RD)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_full(cmd_full),
    .cmd_period(cmd_period), .abort(abort), .make_step(make_step),
    .dir_out(dir_out), .full_out(full_out), .busy(busy), .done(done),
    .steps_left(steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cycle;
    int left;
    bit dir;
    bit full;
  } pulse_t;

  pulse_t pulse_q[$];
  int     done_q[$];
  int     n_vec = 0;
  int     n_bad = 0;
  bit     prev_ms = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference schedule: pulse cycles and steps_left shown with each pulse.
  // Cycle numbers count posedges; accept happens on posedge acc.
  task automatic model_move(input int acc, input int steps, input int period,
                            input int abort_after, input bit dir, input bit full);
    int pc, p, p_before, ramp, left, t, k;
    bit accel, decel;
    pc    = imax(period, 2);
    p     = imax(pc, SP);
    accel = (pc < SP);
    decel = 1'b0;
    ramp  = 0;
    left  = steps;
    t     = acc;
    k     = 0;
    if (steps == 0) begin
      done_q.push_back(acc);
      return;
    end
    while (1) begin
      k++;
      t += p;
      pulse_q.push_back('{cycle: t, left: left, dir: dir, full: full});
      left--;
      if (left == 0) begin
        done_q.push_back(t + 1);
        return;
      end
      if (decel) begin
        p = imin(p + RD, SP);
      end else begin
        p_before = p;
        if (accel) begin
          ramp++;
          p = imax(p - RD, pc);
          if (p == pc) accel = 1'b0;
        end
        if (left <= ramp) begin
          decel = 1'b1;
          p     = imin(p_before + RD, SP);
        end
      end
      if (k == abort_after && !decel) begin
        left = imin(left, ramp);
        if (left == 0) begin
          done_q.push_back(t + 2);
          return;
        end
        decel = 1'b1;
        p     = imin(p + RD, SP);
      end
    end
  endtask

  // Monitor: compares every observed pulse and done against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      prev_ms = 1'b0;
    end else begin
      if (make_step) begin
        pulse_t e;
        check(!prev_ms, "no_back_to_back", 1, 0);
        if (pulse_q.size() == 0) begin
          check(1'b0, "unexpected_pulse", cyc, -1);
        end else begin
          e = pulse_q.pop_front();
          check(cyc == e.cycle, "pulse_cycle", cyc, e.cycle);
          check(int'(steps_left) == e.left, "steps_left_at_pulse", steps_left, e.left);
          check(dir_out == e.dir, "dir_out", dir_out, e.dir);
          check(full_out == e.full, "full_out", full_out, e.full);
        end
      end
      if (done) begin
        int d;
        if (done_q.size() == 0) begin
          check(1'b0, "unexpected_done", cyc, -1);
        end else begin
          d = done_q.pop_front();
          check(cyc == d, "done_cycle", cyc, d);
          check(!busy, "idle_at_done", busy, 0);
          check(steps_left == '0, "zero_left_at_done", steps_left, 0);
        end
      end
      prev_ms = make_step;
    end
  end

  task automatic check_reset_values();
    check(make_step == 1'b0, "rst_make_step", make_step, 0);
    check(dir_out == 1'b1, "rst_dir_out", dir_out, 1);
    check(full_out == 1'b1, "rst_full_out", full_out, 1);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check(steps_left == '0, "rst_steps_left", steps_left, 0);
    check(cmd_ready == 1'b1, "rst_cmd_ready", cmd_ready, 1);
  endtask

  // Issue one move, optionally raising abort after pulse abort_after and
  // poking cmd_valid with junk while busy; waits (bounded) for done.
  task automatic run_move(input int steps, input int period, input bit dir, input bit full,
                          input int abort_after, input bit inject);
    int seen, budget, acc;
    bit finished;
    @(negedge clk);
    check(cmd_ready == 1'b1, "ready_when_idle", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_steps  = CNT_W'(steps);
    cmd_period = DIV_W'(period);
    cmd_dir    = dir;
    cmd_full   = full;
    acc        = cyc + 1;
    model_move(acc, steps, period, abort_after, dir, full);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check(int'(steps_left) == steps, "steps_latched", steps_left, steps);
    check(busy == (steps != 0), "busy_after_accept", busy, steps != 0);
    seen     = 0;
    finished = 1'b0;
    budget   = (steps + 2) * (imax(period, SP) + 2) + 20;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (make_step) begin
        seen++;
        if (abort_after != 0 && seen == abort_after) abort = 1'b1;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
      cmd_valid = inject && busy && ($urandom_range(0, 7) == 0);
      if (cmd_valid) begin
        cmd_steps  = CNT_W'($urandom_range(0, 50));
        cmd_period = DIV_W'($urandom_range(0, 60));
        cmd_dir    = $urandom_range(0, 1) == 1;
        cmd_full   = $urandom_range(0, 1) == 1;
      end
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check(finished, "done_within_budget", finished, 1);
    @(negedge clk);
    check(pulse_q.size() == 0, "all_pulses_issued", pulse_q.size(), 0);
    pulse_q.delete();
    done_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps, period, ab, n_after;
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    cmd_dir    = 1'b0;
    cmd_full   = 1'b0;
    abort      = 1'b0;
    #12;
    check_reset_values();
    @(negedge clk);
    rst = 1'b1;

    // Directed moves from the ramp description.
    run_move(4,   30, 1'b0, 1'b1, 0,  1'b0);  // cruise only
    run_move(10,  10, 1'b1, 1'b0, 0,  1'b1);  // full trapezoid
    run_move(3,   10, 1'b0, 1'b0, 0,  1'b0);  // braking before cruise
    run_move(100, 10, 1'b1, 1'b1, 50, 1'b0);  // abort in cruise
    run_move(0,   10, 1'b0, 1'b1, 0,  1'b0);  // empty move
    run_move(6,   0,  1'b1, 1'b0, 0,  1'b1);  // period clamped to 2
    run_move(5,   1,  1'b0, 1'b1, 0,  1'b0);  // period clamped to 2
    run_move(8,   12, 1'b1, 1'b1, 1,  1'b0);  // abort during accel
    run_move(1,   5,  1'b0, 1'b0, 0,  1'b1);  // single step

    // Randomized moves.
    for (int n = 0; n < 25; n++) begin
      steps  = $urandom_range(0, 30);
      period = $urandom_range(0, 40);
      ab     = 0;
      if (period >= 3 && steps > 0 && $urandom_range(0, 2) == 0)
        ab = $urandom_range(1, steps);
      run_move(steps, period, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               ab, $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of a cruising move.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_steps  = CNT_W'(200);
    cmd_period = DIV_W'(25);
    cmd_dir    = 1'b0;
    cmd_full   = 1'b0;
    model_move(cyc + 1, 200, 25, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (80) @(negedge clk);
    check(busy == 1'b1, "busy_before_reset", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values();
    pulse_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    n_after = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (make_step) n_after++;
    end
    check(n_after == 0, "no_pulse_after_reset", n_after, 0);
    check(busy == 1'b0, "idle_after_reset", busy, 0);
    run_move(3, 10, 1'b1, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
